calendar_date_counter: RTL and testbench
========================================

Name: calendar_date_counter

Overview:
- Date stage directly downstream of the seconds/minutes/hours counter chain.
- Consumes the one-cycle day pulse produced when the hour chain wraps 23->00.
- Maintains day, month and year in BCD and applies the joint end-of-month and end-of-year rules (28/29/30/31 days, month 12) that plain modulo counters cannot handle.
- Outputs drive the date pages of the seven-segment display mux directly.

Parameters:
- YEAR_RST, 8'h00: BCD year loaded on clr; represents 20YY, valid range 00-99.
- MONTH_RST, 8'h01: BCD month loaded on clr.
- DAY_RST, 8'h01: BCD day loaded on clr.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- clr  input  1  reset; asynchronous, active-high; forces reset values immediately.
- day_tick  input  1  single-cycle pulse, synchronous to clk; advance date by one day.
- load  input  1  single-cycle pulse; request to overwrite the date with ld_year/ld_month/ld_day.
- ld_year  input  8  BCD year, [7:4] tens, [3:0] ones.
- ld_month  input  8  BCD month.
- ld_day  input  8  BCD day.
- year  output  8  BCD year, registered.
- month  output  8  BCD month, registered.
- day  output  8  BCD day, registered.
- year_rco  output  1  one-cycle pulse when the year wraps 99->00.
- load_err  output  1  one-cycle pulse when a load is rejected.

Behaviour:
- Reset (clr high, asynchronous): year=YEAR_RST, month=MONTH_RST, day=DAY_RST, year_rco=0, load_err=0. State is held while clr is high. The first rising edge after clr falls is a normal cycle.
- Pulse outputs: year_rco and load_err are high for exactly the single cycle after the triggering edge, then return to 0.
- Days in month (dim), computed combinationally from the current or candidate year/month:
  - 31 for months 01,03,05,07,08,10,12.
  - 30 for months 04,06,09,11.
  - 29 for month 02 when the year is a leap year, otherwise 28.
- Leap year (mod-4 only; the 2000-2099 range makes the century rule unnecessary), decided directly on the BCD digits:
  - tens digit even and ones digit in {0,4,8}, or
  - tens digit odd and ones digit in {2,6}.
  - 00 is a leap year.
- day_tick (no load the same cycle); results are visible on outputs 1 cycle after the sampling edge:
  - day < dim: increment day in BCD (09->10, 19->20, 29->30).
  - day == dim and month < 12: day=01, increment month in BCD (09->10).
  - day == dim and month == 12: day=01, month=01, increment year in BCD.
  - year == 99 in that case: year=00 and year_rco=1 for one cycle.
- load:
  - Load is accepted only if all of the following hold:
    - every nibble is <= 9;
    - month is 01-12;
    - day is 01 through dim(ld_year, ld_month).
  - Accepted: all three registers update on that edge.
  - Rejected: no register changes; load_err=1 for one cycle.
  - load has priority over a same-cycle day_tick. That tick is discarded, not deferred.
- day_tick while clr is high is ignored.
- Held-high inputs: back-to-back day_tick on consecutive cycles each advance one day. No edge detection is performed; a held-high tick advances every cycle, and so does a held-high load.
- Registered day/month/year never hold non-BCD or out-of-range values.
- No other internal state exists; no FSM beyond the date registers themselves.

Test Plan:
- clr pulse mid-count (state 2023-07-15) -> outputs 00/01/01 immediately while clr is high, without waiting for a clk edge; year_rco=0, load_err=0.
- Load 24/02/28, day_tick -> 24/02/29; day_tick -> 24/03/01. Load 23/02/28, day_tick -> 23/03/01.
- Load 99/12/31, day_tick -> 00/01/01 with year_rco=1 for exactly one cycle.
- Load 21/04/30, tick -> 21/05/01. Load 21/09/30, tick -> 21/10/01. Load 21/01/09, tick -> 21/01/10.
- Invalid loads (21/02/29, 21/13/01, 21/00/05, 21/04/31, 2A/01/01) from state 20/06/06 -> state unchanged; load_err pulses once per attempt.
- load 22/08/08 asserted with day_tick in the same cycle -> 22/08/08, not 22/08/09. Subsequent 3 consecutive ticks -> 22/08/11.

Source files
------------

// File: rtl/calendar_date_counter_if.sv
// Date-stage bus: day tick and load request in, BCD date and event pulses out.
interface calendar_date_counter_if;
    localparam int unsigned BCD_W = 8;

    logic             day_tick;
    logic             load;
    logic [BCD_W-1:0] ld_year;
    logic [BCD_W-1:0] ld_month;
    logic [BCD_W-1:0] ld_day;
    logic [BCD_W-1:0] year;
    logic [BCD_W-1:0] month;
    logic [BCD_W-1:0] day;
    logic             year_rco;
    logic             load_err;

    modport master (
        output day_tick, load, ld_year, ld_month, ld_day,
        input  year, month, day, year_rco, load_err
    );

    modport slave (
        input  day_tick, load, ld_year, ld_month, ld_day,
        output year, month, day, year_rco, load_err
    );
endinterface

// File: rtl/calendar_date_counter.sv
// BCD day/month/year counter for 2000-2099, advanced by the hour-chain day pulse,
// with validated parallel load and year-wrap / load-reject pulses.
module calendar_date_counter #(
    parameter logic [7:0] YEAR_RST  = 8'h00,
    parameter logic [7:0] MONTH_RST = 8'h01,
    parameter logic [7:0] DAY_RST   = 8'h01
) (
    input logic                  clk,
    input logic                  clr,
    calendar_date_counter_if.slave bus
);
    localparam int unsigned BCD_W = 8;
    localparam int unsigned DIG_W = 4;

    typedef logic [BCD_W-1:0] bcd_t;

    // Both digits in 0-9.
    function automatic logic bcd_valid(input bcd_t x);
        return (x[7:4] <= DIG_W'(9)) && (x[3:0] <= DIG_W'(9));
    endfunction

    // Mod-4 leap test evaluated on the BCD digits directly.
    function automatic logic is_leap(input bcd_t y);
        logic [DIG_W-1:0] ones;
        ones = y[3:0];
        if (!y[4])
            return (ones == DIG_W'(0)) || (ones == DIG_W'(4)) || (ones == DIG_W'(8));
        else
            return (ones == DIG_W'(2)) || (ones == DIG_W'(6));
    endfunction

    // Invalid months yield 00 so any day fails the range check.
    function automatic bcd_t days_in_month(input bcd_t y, input bcd_t m);
        case (m)
            8'h01, 8'h03, 8'h05, 8'h07, 8'h08, 8'h10, 8'h12: return 8'h31;
            8'h04, 8'h06, 8'h09, 8'h11:                      return 8'h30;
            8'h02:   return is_leap(y) ? 8'h29 : 8'h28;
            default: return 8'h00;
        endcase
    endfunction

    // Two-digit BCD increment; callers never pass 99.
    function automatic bcd_t bcd_inc(input bcd_t x);
        if (x[3:0] == DIG_W'(9))
            return {x[7:4] + DIG_W'(1), DIG_W'(0)};
        else
            return {x[7:4], x[3:0] + DIG_W'(1)};
    endfunction

    bcd_t year_q,  month_q,  day_q;
    bcd_t year_d,  month_d,  day_d;
    logic rco_q,   err_q;
    logic rco_d,   err_d;

    bcd_t dim_cur_c;
    bcd_t dim_ld_c;
    logic load_ok_c;

    // Load validation; BCD ordering matches binary ordering once digits are valid.
    always_comb begin
        dim_cur_c = days_in_month(year_q, month_q);
        dim_ld_c  = days_in_month(bus.ld_year, bus.ld_month);
        load_ok_c = bcd_valid(bus.ld_year) && bcd_valid(bus.ld_month) &&
                    bcd_valid(bus.ld_day) &&
                    (bus.ld_month >= 8'h01) && (bus.ld_month <= 8'h12) &&
                    (bus.ld_day >= 8'h01) && (bus.ld_day <= dim_ld_c);
    end

    // Next-date selection; load wins over a same-cycle tick.
    always_comb begin
        year_d  = year_q;
        month_d = month_q;
        day_d   = day_q;
        rco_d   = 1'b0;
        err_d   = 1'b0;
        if (bus.load) begin
            if (load_ok_c) begin
                year_d  = bus.ld_year;
                month_d = bus.ld_month;
                day_d   = bus.ld_day;
            end else begin
                err_d = 1'b1;
            end
        end else if (bus.day_tick) begin
            if (day_q != dim_cur_c) begin
                day_d = bcd_inc(day_q);
            end else begin
                day_d = 8'h01;
                if (month_q != 8'h12) begin
                    month_d = bcd_inc(month_q);
                end else begin
                    month_d = 8'h01;
                    if (year_q == 8'h99) begin
                        year_d = 8'h00;
                        rco_d  = 1'b1;
                    end else begin
                        year_d = bcd_inc(year_q);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            year_q  <= YEAR_RST;
            month_q <= MONTH_RST;
            day_q   <= DAY_RST;
            rco_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            year_q  <= year_d;
            month_q <= month_d;
            day_q   <= day_d;
            rco_q   <= rco_d;
            err_q   <= err_d;
        end
    end

    assign bus.year     = year_q;
    assign bus.month    = month_q;
    assign bus.day      = day_q;
    assign bus.year_rco = rco_q;
    assign bus.load_err = err_q;
endmodule

// File: tb/tb_calendar_date_counter.sv
// Directed scoreboard bench for calendar_date_counter.
module tb_calendar_date_counter;
    typedef struct packed {
        logic [7:0] y;
        logic [7:0] m;
        logic [7:0] d;
        logic       rco;
        logic       err;
    } exp_t;

    logic clk;
    logic clr;
    calendar_date_counter_if bus ();

    calendar_date_counter #(
        .YEAR_RST (8'h00),
        .MONTH_RST(8'h01),
        .DAY_RST  (8'h01)
    ) dut (
        .clk(clk),
        .clr(clr),
        .bus(bus)
    );

    exp_t  exp_q[$];
    string tag_q[$];
    int    n_assert = 0;
    int    n_fail   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic expect_now(input string tag, input logic [7:0] y, input logic [7:0] m,
                              input logic [7:0] d, input logic rco, input logic err);
        exp_t e;
        e = '{y: y, m: m, d: d, rco: rco, err: err};
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic check_out();
        exp_t  e;
        exp_t  obs;
        string t;
        obs = '{y: bus.year, m: bus.month, d: bus.day, rco: bus.year_rco, err: bus.load_err};
        n_assert++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty observed=%h expected=entry", obs);
            return;
        end
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        assert (obs === e) else begin
            n_fail++;
            $error("FAIL %s observed y=%h m=%h d=%h rco=%b err=%b expected y=%h m=%h d=%h rco=%b err=%b",
                   t, obs.y, obs.m, obs.d, obs.rco, obs.err, e.y, e.m, e.d, e.rco, e.err);
        end
    endtask

    // One clocked step: drive inputs, queue the expectation, sample 1 time unit after the edge.
    task automatic step(input logic tick, input logic ld, input logic [7:0] ly,
                        input logic [7:0] lm, input logic [7:0] ldd, input string tag,
                        input logic [7:0] ey, input logic [7:0] em, input logic [7:0] ed,
                        input logic erco, input logic eerr);
        bus.day_tick = tick;
        bus.load     = ld;
        bus.ld_year  = ly;
        bus.ld_month = lm;
        bus.ld_day   = ldd;
        expect_now(tag, ey, em, ed, erco, eerr);
        @(posedge clk);
        #1;
        bus.day_tick = 1'b0;
        bus.load     = 1'b0;
        check_out();
    endtask

    task automatic do_load(input logic [7:0] y, input logic [7:0] m, input logic [7:0] d,
                           input string tag);
        step(1'b0, 1'b1, y, m, d, tag, y, m, d, 1'b0, 1'b0);
    endtask

    task automatic do_tick(input string tag, input logic [7:0] y, input logic [7:0] m,
                           input logic [7:0] d, input logic rco);
        step(1'b1, 1'b0, 8'h00, 8'h00, 8'h00, tag, y, m, d, rco, 1'b0);
    endtask

    task automatic bad_load(input logic [7:0] y, input logic [7:0] m, input logic [7:0] d,
                            input string tag);
        step(1'b0, 1'b1, y, m, d, tag, 8'h20, 8'h06, 8'h06, 1'b0, 1'b1);
    endtask

    initial begin
        clr          = 1'b1;
        bus.day_tick = 1'b0;
        bus.load     = 1'b0;
        bus.ld_year  = 8'h00;
        bus.ld_month = 8'h00;
        bus.ld_day   = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        expect_now("reset", 8'h00, 8'h01, 8'h01, 1'b0, 1'b0);
        check_out();
        clr = 1'b0;

        // Asynchronous clear mid-count, and a tick ignored while clear is held.
        do_load(8'h23, 8'h07, 8'h15, "load_230715");
        do_tick("tick_230716", 8'h23, 8'h07, 8'h16, 1'b0);
        #2;
        clr = 1'b1;
        #1;
        expect_now("clr_async", 8'h00, 8'h01, 8'h01, 1'b0, 1'b0);
        check_out();
        bus.day_tick = 1'b1;
        expect_now("clr_tick_ignored", 8'h00, 8'h01, 8'h01, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check_out();
        bus.day_tick = 1'b0;
        clr = 1'b0;
        do_tick("after_clr", 8'h00, 8'h01, 8'h02, 1'b0);

        // February in leap and common years.
        do_load(8'h24, 8'h02, 8'h28, "load_240228");
        do_tick("leap_feb29", 8'h24, 8'h02, 8'h29, 1'b0);
        do_tick("leap_mar01", 8'h24, 8'h03, 8'h01, 1'b0);
        do_load(8'h23, 8'h02, 8'h28, "load_230228");
        do_tick("common_mar01", 8'h23, 8'h03, 8'h01, 1'b0);

        // Century wrap and a December rollover without wrap.
        do_load(8'h99, 8'h12, 8'h31, "load_991231");
        do_tick("year_wrap", 8'h00, 8'h01, 8'h01, 1'b1);
        step(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, "rco_clears", 8'h00, 8'h01, 8'h01, 1'b0, 1'b0);
        do_load(8'h21, 8'h12, 8'h31, "load_211231");
        do_tick("year_inc", 8'h22, 8'h01, 8'h01, 1'b0);

        // 30-day months and BCD digit carries.
        do_load(8'h21, 8'h04, 8'h30, "load_210430");
        do_tick("apr_end", 8'h21, 8'h05, 8'h01, 1'b0);
        do_load(8'h21, 8'h09, 8'h30, "load_210930");
        do_tick("sep_end", 8'h21, 8'h10, 8'h01, 1'b0);
        do_load(8'h21, 8'h01, 8'h09, "load_210109");
        do_tick("day_carry", 8'h21, 8'h01, 8'h10, 1'b0);
        do_load(8'h21, 8'h01, 8'h19, "load_210119");
        do_tick("day_carry2", 8'h21, 8'h01, 8'h20, 1'b0);

        // Leap-year digit rules accepted at Feb 29.
        do_load(8'h00, 8'h02, 8'h29, "leap_00");
        do_load(8'h12, 8'h02, 8'h29, "leap_12");
        do_load(8'h96, 8'h02, 8'h29, "leap_96");
        do_load(8'h20, 8'h02, 8'h29, "leap_20");

        // Rejected loads leave the date alone and pulse load_err each attempt.
        do_load(8'h20, 8'h06, 8'h06, "load_200606");
        bad_load(8'h21, 8'h02, 8'h29, "rej_210229");
        bad_load(8'h21, 8'h13, 8'h01, "rej_month13");
        bad_load(8'h21, 8'h00, 8'h05, "rej_month00");
        bad_load(8'h21, 8'h04, 8'h31, "rej_210431");
        bad_load(8'h2A, 8'h01, 8'h01, "rej_year2A");
        bad_load(8'h19, 8'h02, 8'h29, "rej_190229");
        bad_load(8'h21, 8'h05, 8'h00, "rej_day00");
        bad_load(8'h21, 8'h05, 8'h1A, "rej_day1A");
        step(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, "err_clears", 8'h20, 8'h06, 8'h06, 1'b0, 1'b0);

        // Load beats a same-cycle tick; then held-high ticks advance every cycle.
        step(1'b1, 1'b1, 8'h22, 8'h08, 8'h08, "load_over_tick", 8'h22, 8'h08, 8'h08, 1'b0, 1'b0);
        do_tick("held_tick1", 8'h22, 8'h08, 8'h09, 1'b0);
        do_tick("held_tick2", 8'h22, 8'h08, 8'h10, 1'b0);
        do_tick("held_tick3", 8'h22, 8'h08, 8'h11, 1'b0);

        n_assert++;
        assert (exp_q.size() == 0) else begin
            n_fail++;
            $error("FAIL scoreboard_drain observed=%0d expected=0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
